// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART receive path.
// Parity support is selected in the receiver by defining UART_RX_PARITY_EN.
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } rx_state_e;

  localparam int unsigned DefDataBits   = 8;
  localparam int unsigned DefOversample = 16;
  localparam int unsigned DefStopBits   = 1;

  // Ticks from start-bit detection to the final stop-bit sample.
  function automatic int unsigned frame_ticks(input int unsigned data_bits,
                                              input int unsigned oversample,
                                              input int unsigned stop_bits,
                                              input int unsigned parity_bits);
    return oversample / 2 + oversample * (data_bits + parity_bits + stop_bits);
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Oversample counter for the receive FSM: strobes the half-bit and full-bit
// sampling points, qualified by sample_tick.
module uart_bit_timer #(
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic sample_tick,
  input  logic clear,
  input  logic enable,
  output logic half_pt,
  output logic full_pt
);

  localparam int unsigned CntW = $clog2(OVERSAMPLE);
  localparam logic [CntW-1:0] HalfVal = CntW'(OVERSAMPLE / 2 - 1);
  localparam logic [CntW-1:0] FullVal = CntW'(OVERSAMPLE - 1);

  logic [CntW-1:0] os_cnt_q, os_cnt_d;

  always_comb begin
    os_cnt_d = os_cnt_q;
    if (clear) begin
      os_cnt_d = '0;
    end else if (enable && sample_tick) begin
      os_cnt_d = (os_cnt_q == FullVal) ? '0 : os_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      os_cnt_q <= '0;
    end else begin
      os_cnt_q <= os_cnt_d;
    end
  end

  assign half_pt = enable && sample_tick && (os_cnt_q == HalfVal);
  assign full_pt = enable && sample_tick && (os_cnt_q == FullVal);

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: start qualification, mid-bit sampling, stop check and
// valid/ready delivery. Define UART_RX_PARITY_EN to add a parity bit and parity_err.
module uart_rx_ctrl import uart_pkg::*; #(
  parameter int unsigned DATA_BITS  = DefDataBits,
  parameter int unsigned OVERSAMPLE = DefOversample,
  parameter int unsigned STOP_BITS  = DefStopBits
`ifdef UART_RX_PARITY_EN
  ,
  parameter int unsigned PARITY_ODD = 0
`endif
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sample_tick,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun,
`ifdef UART_RX_PARITY_EN
  output logic                 parity_err,
`endif
  output logic                 busy
);

  localparam int unsigned BcW = $clog2(DATA_BITS + 1);
  localparam logic [BcW-1:0] LastData = BcW'(DATA_BITS - 1);
  localparam logic [BcW-1:0] LastStop = BcW'(STOP_BITS - 1);

  rx_state_e            state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [BcW-1:0]       bit_cnt_q, bit_cnt_d;
  logic                 armed_q, armed_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;
  logic                 deliver;
  logic                 half_pt, full_pt;
  logic                 timer_clear;
`ifdef UART_RX_PARITY_EN
  logic                 par_q, par_d;
  logic                 parity_err_q, parity_err_d;
`endif

  // Counter restarts on every state change and is held at zero while idle.
  assign timer_clear = (state_d != state_q) || (state_q == StIdle);

  uart_bit_timer #(
    .OVERSAMPLE (OVERSAMPLE)
  ) u_bit_timer (
    .clk         (clk),
    .reset       (reset),
    .sample_tick (sample_tick),
    .clear       (timer_clear),
    .enable      (state_q != StIdle),
    .half_pt     (half_pt),
    .full_pt     (full_pt)
  );

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    armed_d     = armed_q;
    frame_err_d = 1'b0;
    deliver     = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d       = par_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (sample_tick) begin
          if (rxd) begin
            armed_d = 1'b1;
          end else if (armed_q) begin
            state_d = StStart;
          end
        end
      end
      StStart: begin
        if (half_pt) begin
          if (rxd) begin
            state_d = StIdle;
          end else begin
            bit_cnt_d = '0;
            state_d   = StData;
          end
        end
      end
      StData: begin
        if (full_pt) begin
          shift_d = {rxd, shift_q[DATA_BITS-1:1]};
          if (bit_cnt_q == LastData) begin
            bit_cnt_d = '0;
`ifdef UART_RX_PARITY_EN
            state_d   = StParity;
`else
            state_d   = StStop;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      StParity: begin
        if (full_pt) begin
          par_d   = rxd;
          state_d = StStop;
        end
      end
`endif
      StStop: begin
        if (full_pt) begin
          if (!rxd) begin
            // Disarm so a held-low line (break) is not re-received as a frame.
            frame_err_d = 1'b1;
            armed_d     = 1'b0;
            bit_cnt_d   = '0;
            state_d     = StIdle;
          end else if (bit_cnt_q == LastStop) begin
            deliver   = 1'b1;
            bit_cnt_d = '0;
            state_d   = StIdle;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    overrun_d  = 1'b0;
    if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end
    if (deliver) begin
      if (!rx_valid_q || rx_ready) begin
        rx_data_d  = shift_q;
        rx_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  assign parity_err_d = deliver && ((^shift_q ^ par_q) != 1'(PARITY_ODD));
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      armed_q      <= 1'b1;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q        <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      armed_q      <= armed_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
`ifdef UART_RX_PARITY_EN
      par_q        <= par_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != StIdle);
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`endif

endmodule
